spmem_arbiter: RTL and testbench

//  Shares one single-port scratchpad memory (spmem) between NUM_REQ requesters, e.g. DMA and compute engine.

---
 rtl/spmem_arbiter.sv | 140 ++++++++++++++
 tb/tb_spmem_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmem_arbiter.sv
// Round-robin arbiter sharing one single-port scratchpad between NUM_REQ requesters,
// with registered issue and read-data routing by in-flight tag. Optional burst lock: SPMEM_ARB_LOCK_EN.
module spmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                          spmem_clk,
  input  logic                          spmem_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_wr_n,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_be,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_d,
`ifdef SPMEM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_lock,
`endif
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_q,
  output logic                          spmem_cs_n,
  output logic [ADDR_WIDTH-1:0]         spmem_addr,
  output logic                          spmem_wr_n,
  output logic [DATA_WIDTH-1:0]         spmem_be,
  output logic [DATA_WIDTH-1:0]         spmem_d,
  input  logic [DATA_WIDTH-1:0]         spmem_q
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Handshake: a request transfers in any cycle where req_valid[i] & req_ready[i].
  // req_ready is a combinational function of req_valid, so req_valid must never
  // wait on req_ready; the requester holds its fields stable while valid is high.

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gnt_id;
  logic          gnt_found;
  logic          hs;
  logic [PW:0]   scan;
  logic [PW-1:0] scan_id;
  logic [PW-1:0] issue_id;

  logic [RD_LATENCY-1:0] tag_v;
  logic [PW-1:0]         tag_id [RD_LATENCY];

`ifdef SPMEM_ARB_LOCK_EN
  logic          lock_active;
  logic [PW-1:0] lock_id;
`endif

  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = rr_ptr;
    scan      = '0;
    scan_id   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr} + (PW+1)'(k);
      if (scan >= (PW+1)'(NUM_REQ)) scan = scan - (PW+1)'(NUM_REQ);
      scan_id = scan[PW-1:0];
      if (!gnt_found && req_valid[scan_id]) begin
        gnt_found = 1'b1;
        gnt_id    = scan_id;
      end
    end
`ifdef SPMEM_ARB_LOCK_EN
    // A held lock overrides rotation; the owner going idle stalls everyone.
    if (lock_active) begin
      gnt_found = req_valid[lock_id];
      gnt_id    = lock_id;
    end
`endif
  end

  assign hs = gnt_found & spmem_rst_n;

  always_comb begin
    req_ready = '0;
    if (hs) req_ready[gnt_id] = 1'b1;
  end

  always_ff @(posedge spmem_clk) begin
    if (!spmem_rst_n) begin
      spmem_cs_n <= 1'b1;
      spmem_wr_n <= 1'b1;
      spmem_addr <= '0;
      spmem_be   <= '0;
      spmem_d    <= '0;
      rr_ptr     <= PW'(NUM_REQ - 1);
      issue_id   <= '0;
    end else if (hs) begin
      spmem_cs_n <= 1'b0;
      spmem_wr_n <= req_wr_n[gnt_id];
      spmem_addr <= req_addr[gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
      spmem_be   <= req_be[gnt_id*DATA_WIDTH +: DATA_WIDTH];
      spmem_d    <= req_d[gnt_id*DATA_WIDTH +: DATA_WIDTH];
      rr_ptr     <= gnt_id;
      issue_id   <= gnt_id;
    end else begin
      spmem_cs_n <= 1'b1;
      spmem_wr_n <= 1'b1;
      spmem_be   <= '0;
    end
  end

`ifdef SPMEM_ARB_LOCK_EN
  always_ff @(posedge spmem_clk) begin
    if (!spmem_rst_n) begin
      lock_active <= 1'b0;
      lock_id     <= '0;
    end else if (hs) begin
      lock_active <= req_lock[gnt_id];
      lock_id     <= gnt_id;
    end
  end
`endif

  // Tag stage 0 captures the read as the memory sees it; the last stage lines up with spmem_q.
  always_ff @(posedge spmem_clk) begin
    if (!spmem_rst_n) begin
      tag_v <= '0;
      for (int i = 0; i < RD_LATENCY; i++) tag_id[i] <= '0;
    end else begin
      tag_v[0]  <= ~spmem_cs_n & spmem_wr_n;
      tag_id[0] <= issue_id;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (tag_v[RD_LATENCY-1] && spmem_rst_n) rsp_valid[tag_id[RD_LATENCY-1]] = 1'b1;
  end

  assign rsp_q = spmem_q;

endmodule

// File: tb/tb_spmem_arbiter.sv
// Bench for spmem_arbiter: two instances (read latency 1 and 3) share stimulus and are
// compared every cycle against a transaction-level model; directed steps pin key values.
module tb_spmem_arbiter;

  localparam int NR = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int QW = 72;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_wr_n;
  logic [NR-1:0]     req_lock;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_be;
  logic [NR*DW-1:0]  req_d;

  logic [NR-1:0]     ready_a [2];
  logic [NR-1:0]     rv_a    [2];
  logic [DW-1:0]     rq_a    [2];
  logic              cs_a    [2];
  logic              wr_a    [2];
  logic [AW-1:0]     addr_a  [2];
  logic [DW-1:0]     be_a    [2];
  logic [DW-1:0]     d_a     [2];
  logic [DW-1:0]     q_a     [2];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  spmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .RD_LATENCY(1)) dut0 (
    .spmem_clk   (clk),
    .spmem_rst_n (rst_n),
    .req_valid   (req_valid),
    .req_ready   (ready_a[0]),
    .req_wr_n    (req_wr_n),
    .req_addr    (req_addr),
    .req_be      (req_be),
    .req_d       (req_d),
`ifdef SPMEM_ARB_LOCK_EN
    .req_lock    (req_lock),
`endif
    .rsp_valid   (rv_a[0]),
    .rsp_q       (rq_a[0]),
    .spmem_cs_n  (cs_a[0]),
    .spmem_addr  (addr_a[0]),
    .spmem_wr_n  (wr_a[0]),
    .spmem_be    (be_a[0]),
    .spmem_d     (d_a[0]),
    .spmem_q     (q_a[0])
  );

  spmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .RD_LATENCY(3)) dut1 (
    .spmem_clk   (clk),
    .spmem_rst_n (rst_n),
    .req_valid   (req_valid),
    .req_ready   (ready_a[1]),
    .req_wr_n    (req_wr_n),
    .req_addr    (req_addr),
    .req_be      (req_be),
    .req_d       (req_d),
`ifdef SPMEM_ARB_LOCK_EN
    .req_lock    (req_lock),
`endif
    .rsp_valid   (rv_a[1]),
    .rsp_q       (rq_a[1]),
    .spmem_cs_n  (cs_a[1]),
    .spmem_addr  (addr_a[1]),
    .spmem_wr_n  (wr_a[1]),
    .spmem_be    (be_a[1]),
    .spmem_d     (d_a[1]),
    .spmem_q     (q_a[1])
  );

  function automatic logic [DW-1:0] pat(input int a);
    logic [7:0] b;
    b = 8'(a);
    return {8'h5A, b, ~b, 8'hC3};
  endfunction

  // ---------------- memory devices (one per instance) ----------------
  logic [DW-1:0] dev_mem [2][256];
  logic [DW-1:0] qp      [2][4];

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int k = 0; k < 2; k++) begin
        for (int a = 0; a < 256; a++) dev_mem[k][a] <= pat(a);
        for (int s = 0; s < 4; s++) qp[k][s] <= 32'hDEADBEEF;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (cs_a[k] === 1'b0 && wr_a[k] === 1'b0)
          dev_mem[k][addr_a[k][7:0]] <= (dev_mem[k][addr_a[k][7:0]] & ~be_a[k]) | (d_a[k] & be_a[k]);
        qp[k][0] <= (cs_a[k] === 1'b0 && wr_a[k] === 1'b1) ? dev_mem[k][addr_a[k][7:0]] : 32'hDEADBEEF;
        for (int s = 1; s < 4; s++) qp[k][s] <= qp[k][s-1];
      end
    end
  end

  assign q_a[0] = qp[0][0];
  assign q_a[1] = qp[1][2];

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  logic [QW-1:0] exp_q0[$];
  logic [QW-1:0] exp_q1[$];
  logic [DW-1:0] m_mem [256];
  bit            m_init = 0;
  bit            chk_en = 0;
  int            m_last = NR - 1;
  bit            m_lock = 0;
  int            m_lock_id = 0;
  int            g;
  int            j;
  logic [NR-1:0] e_ready;
  logic [NR-1:0] e_rv;
  logic          e_cs, e_wr;
  logic [AW-1:0] e_addr, a_tmp;
  logic [DW-1:0] e_be, e_d, be_tmp, d_tmp;
  logic [QW-1:0] ent;
  bit            have;

  always @(negedge clk) begin
    if (!m_init) begin
      for (int a = 0; a < 256; a++) m_mem[a] = pat(a);
      m_init = 1;
    end
    // Grant by rule: lock owner if locked, else first valid after the last grant.
    g = -1;
    if (rst_n === 1'b1) begin
      if (m_lock) begin
        if (req_valid[m_lock_id]) g = m_lock_id;
      end else begin
        for (int k = 1; k <= NR; k++) begin
          j = (m_last + k) % NR;
          if (g < 0 && req_valid[j]) g = j;
        end
      end
    end
    e_ready = '0;
    if (g >= 0) e_ready[g] = 1'b1;
    chk("req_ready_l1", 64'(ready_a[0]), 64'(e_ready));
    chk("req_ready_l3", 64'(ready_a[1]), 64'(e_ready));

    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("spmem_cs_n", 64'(cs_a[k]), 64'(e_cs));
        chk("spmem_wr_n", 64'(wr_a[k]), 64'(e_wr));
        chk("spmem_addr", 64'(addr_a[k]), 64'(e_addr));
        chk("spmem_be", 64'(be_a[k]), 64'(e_be));
        chk("spmem_d", 64'(d_a[k]), 64'(e_d));
        have = 1'b0;
        ent  = '0;
        if (k == 0 && exp_q0.size() > 0) begin
          if (exp_q0[0][71:40] == 32'(cyc)) begin ent = exp_q0.pop_front(); have = 1'b1; end
        end
        if (k == 1 && exp_q1.size() > 0) begin
          if (exp_q1[0][71:40] == 32'(cyc)) begin ent = exp_q1.pop_front(); have = 1'b1; end
        end
        e_rv = '0;
        if (have && rst_n === 1'b1) e_rv[int'(ent[39:32])] = 1'b1;
        chk("rsp_valid", 64'(rv_a[k]), 64'(e_rv));
        if (have && rst_n === 1'b1) chk("rsp_q", 64'(rq_a[k]), 64'(ent[31:0]));
      end
    end

    // What the memory port must show next cycle.
    if (rst_n !== 1'b1) begin
      e_cs = 1'b1; e_wr = 1'b1; e_addr = '0; e_be = '0; e_d = '0;
      m_last = NR - 1;
      m_lock = 0;
      exp_q0.delete();
      exp_q1.delete();
      chk_en = 1;
    end else if (g >= 0) begin
      a_tmp  = req_addr[g*AW +: AW];
      be_tmp = req_be[g*DW +: DW];
      d_tmp  = req_d[g*DW +: DW];
      e_cs = 1'b0; e_wr = req_wr_n[g]; e_addr = a_tmp; e_be = be_tmp; e_d = d_tmp;
      if (!req_wr_n[g]) begin
        m_mem[a_tmp[7:0]] = (m_mem[a_tmp[7:0]] & ~be_tmp) | (d_tmp & be_tmp);
      end else begin
        exp_q0.push_back({32'(cyc + 2), 8'(g), m_mem[a_tmp[7:0]]});
        exp_q1.push_back({32'(cyc + 4), 8'(g), m_mem[a_tmp[7:0]]});
      end
      m_last = g;
`ifdef SPMEM_ARB_LOCK_EN
      m_lock    = req_lock[g];
      m_lock_id = g;
`endif
    end else begin
      e_cs = 1'b1; e_wr = 1'b1; e_be = '0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic wr_n, input logic [AW-1:0] addr,
                       input logic [DW-1:0] d, input logic [DW-1:0] be, input logic lock);
    req_valid[i]          = v;
    req_wr_n[i]           = wr_n;
    req_addr[i*AW +: AW]  = addr;
    req_d[i*DW +: DW]     = d;
    req_be[i*DW +: DW]    = be;
    req_lock[i]           = lock;
  endtask

  task automatic idle_all();
    req_valid = '0;
    req_lock  = '0;
  endtask

  // ---------------- directed stimulus ----------------
  int cnt0, cnt1;

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_wr_n = '1; req_lock = '0;
    req_addr = '0; req_be = '0; req_d = '0;

    // Reset with everyone requesting.
    drive(0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
    drive(1, 1'b1, 1'b1, 32'h1, 32'h0, 32'h0, 1'b0);
    next_cyc(); next_cyc(); next_cyc();
    @(negedge clk);
    chk("reset_ready", 64'(ready_a[0]), 64'(2'b00));
    chk("reset_cs_n", 64'(cs_a[0]), 64'(1'b1));
    next_cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_grant", 64'(ready_a[0]), 64'(2'b01));
    next_cyc();
    idle_all();

    // Write then read back, full and partial bit enables.
    next_cyc();
    drive(0, 1'b1, 1'b0, 32'h10, 32'hA5A5A5A5, 32'hFFFFFFFF, 1'b0);
    next_cyc();
    drive(0, 1'b1, 1'b1, 32'h10, 32'h0, 32'h0, 1'b0);
    next_cyc();
    idle_all();
    next_cyc();
    @(negedge clk);
    chk("rd_after_wr_valid", 64'(rv_a[0]), 64'(2'b01));
    chk("rd_after_wr_q", 64'(rq_a[0]), 64'(32'hA5A5A5A5));
    next_cyc();
    drive(0, 1'b1, 1'b0, 32'h10, 32'h12345678, 32'h0000FFFF, 1'b0);
    next_cyc();
    drive(0, 1'b1, 1'b1, 32'h10, 32'h0, 32'h0, 1'b0);
    next_cyc();
    idle_all();
    next_cyc();
    @(negedge clk);
    chk("partial_be_q", 64'(rq_a[0]), 64'(32'hA5A55678));

    // Both requesters read continuously: strict alternation starting at 1.
    next_cyc();
    drive(0, 1'b1, 1'b1, 32'h30, 32'h0, 32'h0, 1'b0);
    drive(1, 1'b1, 1'b1, 32'h31, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rotation", 64'(ready_a[0]), (i % 2 == 0) ? 64'(2'b10) : 64'(2'b01));
      next_cyc();
    end
    idle_all();
    for (int i = 0; i < 5; i++) next_cyc();

    // Four back-to-back reads, then reset right behind the last one.
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1'b1, 1'b1, 32'(32'h40 + i), 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      cnt0 += $countones(rv_a[0]);
      cnt1 += $countones(rv_a[1]);
      next_cyc();
    end
    idle_all();
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) rst_n = 1'b1;
      @(negedge clk);
      cnt0 += $countones(rv_a[0]);
      cnt1 += $countones(rv_a[1]);
      next_cyc();
    end
    chk("flush_rsp_count_l1", 64'(cnt0), 64'(2));
    chk("flush_rsp_count_l3", 64'(cnt1), 64'(0));

    // Single requester streams 16 writes.
    for (int i = 0; i < 16; i++) begin
      drive(1, 1'b1, 1'b0, 32'(32'h80 + i), 32'(32'hC0DE0000 + i), 32'hFFFFFFFF, 1'b0);
      @(negedge clk);
      chk("stream_ready", 64'(ready_a[0]), 64'(2'b10));
      if (i > 0) chk("stream_cs_n", 64'(cs_a[0]), 64'(1'b0));
      next_cyc();
    end
    idle_all();
    @(negedge clk);
    chk("stream_cs_n_last", 64'(cs_a[0]), 64'(1'b0));
    next_cyc();
    @(negedge clk);
    chk("stream_cs_n_end", 64'(cs_a[0]), 64'(1'b1));
    drive(0, 1'b1, 1'b1, 32'h85, 32'h0, 32'h0, 1'b0);
    next_cyc();
    idle_all();
    next_cyc();
    @(negedge clk);
    chk("stream_readback", 64'(rq_a[0]), 64'(32'hC0DE0005));

`ifdef SPMEM_ARB_LOCK_EN
    // Requester 1 holds a three-access lock; requester 0 waits until release.
    next_cyc();
    drive(0, 1'b1, 1'b1, 32'h20, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1'b1, 1'b1, 32'(32'h50 + i), 32'h0, 32'h0, (i < 3) ? 1'b1 : 1'b0);
      @(negedge clk);
      chk("lock_grant", 64'(ready_a[0]), (i < 4) ? 64'(2'b10) : 64'(2'b01));
      next_cyc();
    end
    idle_all();
`endif

    for (int i = 0; i < 8; i++) next_cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
